// File: rtl/tug_pkg.sv
// tug_pkg: shared state encoding and winner codes for the tug-of-war match sequencer
package tug_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, COUNTDOWN, PLAY, POINT, MATCH_OVER} state_t;
    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter; done is high while the count reads 0
// Ports: Clock, Reset (sync, active-high), load/load_val (restart count), done
module cycle_timer #(
    parameter int W = 26
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;
    always_ff @(posedge Clock) begin
        if (Reset) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - W'(1);
    end
    assign done = count == '0;
endmodule

// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: round/match sequencer gating player presses into the tug-of-war light chain
// Ports: Clock, Reset (sync, active-high), start, left_press/right_press, edge_left/edge_right in;
//        game_reset, left_go/right_go, round_active, left_score/right_score, winner out.
// Option: define TUG_FALSE_START_EN to award the round to the opponent on a countdown press.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int WIN_ROUNDS   = 3,
    parameter int SCORE_W      = 3,
    parameter int COUNT_CYCLES = 50000000,
    parameter int HOLD_CYCLES  = 25000000,
    parameter int CNT_W        = 26
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start,
    input  logic               left_press,
    input  logic               right_press,
    input  logic               edge_left,
    input  logic               edge_right,
    output logic               game_reset,
    output logic               left_go,
    output logic               right_go,
    output logic               round_active,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic [1:0]         winner
);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_ROUNDS);
    state_t             state, state_nxt;
    logic [SCORE_W-1:0] ls_nxt, rs_nxt;
    logic [1:0]         w_nxt;
    logic               done, load;
    logic [CNT_W-1:0]   load_val;
    // the timer restarts on every state change, sized for the state being entered
    assign load     = state_nxt != state;
    assign load_val = state_nxt == CLEAR     ? CNT_W'(1) :
                      state_nxt == COUNTDOWN ? CNT_W'(COUNT_CYCLES - 1) :
                                               CNT_W'(HOLD_CYCLES - 1);
    cycle_timer #(.W(CNT_W)) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            left_score  <= '0;
            right_score <= '0;
            winner      <= WIN_NONE;
        end else begin
            state       <= state_nxt;
            left_score  <= ls_nxt;
            right_score <= rs_nxt;
            winner      <= w_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        ls_nxt    = left_score;
        rs_nxt    = right_score;
        w_nxt     = winner;
        case (state)
            IDLE, MATCH_OVER: if (start) begin
                state_nxt = CLEAR;
                ls_nxt    = '0;
                rs_nxt    = '0;
                w_nxt     = WIN_NONE;
            end
            CLEAR: if (done) state_nxt = COUNTDOWN;
            COUNTDOWN: begin
`ifdef TUG_FALSE_START_EN
                if (left_press & ~right_press) begin
                    state_nxt = POINT;
                    rs_nxt    = right_score + SCORE_W'(1);
                end else if (right_press & ~left_press) begin
                    state_nxt = POINT;
                    ls_nxt    = left_score + SCORE_W'(1);
                end else
`endif
                if (done) state_nxt = PLAY;
            end
            PLAY: begin
                // simultaneous presses never score, matching the chain's no-move rule
                if (edge_left & left_press & ~right_press) begin
                    state_nxt = POINT;
                    ls_nxt    = left_score + SCORE_W'(1);
                end else if (edge_right & right_press & ~left_press) begin
                    state_nxt = POINT;
                    rs_nxt    = right_score + SCORE_W'(1);
                end
            end
            POINT: if (done) begin
                if (left_score == WIN || right_score == WIN) begin
                    state_nxt = MATCH_OVER;
                    w_nxt     = left_score == WIN ? WIN_LEFT : WIN_RIGHT;
                end else begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign game_reset   = Reset | (state == IDLE) | (state == CLEAR);
    assign round_active = state == PLAY;
    assign left_go      = left_press & round_active;
    assign right_go     = right_press & round_active;
endmodule

// File: tb/tb_tug_match_ctrl.sv
// tb_tug_match_ctrl: scoreboard bench for tug_match_ctrl with short countdown/hold timings
module tb_tug_match_ctrl;
    import tug_pkg::*;
    logic       Clock = 0, Reset = 1, start = 0;
    logic       left_press = 0, right_press = 0, edge_left = 0, edge_right = 0;
    logic       game_reset, left_go, right_go, round_active;
    logic [1:0] left_score, right_score, winner;
    int         checks = 0, failures = 0;

    typedef struct {
        logic       gr, lg, rg, ra;
        logic [1:0] ls, rs, w;
    } exp_t;
    exp_t   sb[$];
    exp_t   me;
    state_t m_st;
    int     m_rem, m_ls, m_rs, m_w;

    tug_match_ctrl #(
        .WIN_ROUNDS(2), .SCORE_W(2), .COUNT_CYCLES(4), .HOLD_CYCLES(3), .CNT_W(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .start(start),
        .left_press(left_press), .right_press(right_press),
        .edge_left(edge_left), .edge_right(edge_right),
        .game_reset(game_reset), .left_go(left_go), .right_go(right_go),
        .round_active(round_active), .left_score(left_score),
        .right_score(right_score), .winner(winner)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            check("game_reset", {7'd0, game_reset}, {7'd0, me.gr});
            check("left_go", {7'd0, left_go}, {7'd0, me.lg});
            check("right_go", {7'd0, right_go}, {7'd0, me.rg});
            check("round_active", {7'd0, round_active}, {7'd0, me.ra});
            check("left_score", {6'd0, left_score}, {6'd0, me.ls});
            check("right_score", {6'd0, right_score}, {6'd0, me.rs});
            check("winner", {6'd0, winner}, {6'd0, me.w});
        end
    end

    // one clock: drive inputs, push the outputs expected for this cycle, advance the model
    task automatic cyc(input logic r, s, lp, rp, el, er);
        exp_t e;
        @(posedge Clock);
        #1;
        Reset = r; start = s; left_press = lp; right_press = rp; edge_left = el; edge_right = er;
        e.gr = r || m_st == IDLE || m_st == CLEAR;
        e.ra = m_st == PLAY;
        e.lg = lp && m_st == PLAY;
        e.rg = rp && m_st == PLAY;
        e.ls = 2'(m_ls);
        e.rs = 2'(m_rs);
        e.w  = 2'(m_w);
        sb.push_back(e);
        if (r) begin
            m_st = IDLE; m_ls = 0; m_rs = 0; m_w = 0;
        end else begin
            case (m_st)
                IDLE, MATCH_OVER: if (s) begin
                    m_st = CLEAR; m_rem = 2; m_ls = 0; m_rs = 0; m_w = 0;
                end
                CLEAR: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_st = COUNTDOWN; m_rem = 4; end
                end
                COUNTDOWN: begin
`ifdef TUG_FALSE_START_EN
                    if (lp && !rp) begin m_rs++; m_st = POINT; m_rem = 3; end
                    else if (rp && !lp) begin m_ls++; m_st = POINT; m_rem = 3; end
                    else
`endif
                    begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_st = PLAY;
                    end
                end
                PLAY: begin
                    if (el && lp && !rp) begin m_ls++; m_st = POINT; m_rem = 3; end
                    else if (er && rp && !lp) begin m_rs++; m_st = POINT; m_rem = 3; end
                end
                POINT: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        if (m_ls == 2) begin m_st = MATCH_OVER; m_w = 1; end
                        else if (m_rs == 2) begin m_st = MATCH_OVER; m_w = 2; end
                        else begin m_st = CLEAR; m_rem = 2; end
                    end
                end
                default: m_st = IDLE;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to_play(input int budget);
        for (int i = 0; i < budget && m_st != PLAY; i++) cyc(0, 0, 0, 0, 0, 0);
        if (m_st != PLAY) check("play_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        m_st = IDLE; m_rem = 0; m_ls = 0; m_rs = 0; m_w = 0;
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0, 1, 0);
        run_to_play(20);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 0, 1, 0, 1, 0);
        run_to_play(20);
        cyc(0, 0, 1, 0, 1, 0);
        idle(6);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        run_to_play(20);
        cyc(0, 0, 1, 0, 1, 0);
        run_to_play(20);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0);
        run_to_play(20);
        cyc(0, 0, 0, 1, 0, 1);
        run_to_play(20);
        cyc(0, 0, 0, 1, 0, 1);
        idle(6);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        @(negedge Clock);
        #1;
        check("sb_drain", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
